// File: rtl/shared_sbox_layer_if.sv
// Bundle of the three valid/ready channels of the shared S-box F-layer.
// Input beat (two Boolean shares), fresh guard bits and output beat.
interface shared_sbox_layer_if #(
    parameter int NLANE = 16
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [4*NLANE-1:0]   in_sh0;
    logic [4*NLANE-1:0]   in_sh1;
    logic                 rnd_valid;
    logic                 rnd_ready;
    logic [2*NLANE-1:0]   rnd;
    logic                 out_valid;
    logic                 out_ready;
    logic [4*NLANE-1:0]   out_sh0;
    logic [4*NLANE-1:0]   out_sh1;

    // Producer side: drives beats and guards, consumes results.
    modport master (
        output in_valid, in_sh0, in_sh1, rnd_valid, rnd, out_ready,
        input  in_ready, rnd_ready, out_valid, out_sh0, out_sh1
    );

    // Layer side.
    modport slave (
        input  in_valid, in_sh0, in_sh1, rnd_valid, rnd, out_ready,
        output in_ready, rnd_ready, out_valid, out_sh0, out_sh1
    );
endinterface

// File: rtl/shared_sbox_layer.sv
// Two-share masked F-layer of the decomposed S-box, NLANE nibbles per beat.
// Unmasked: e = cd^a^1, f = b, g = c, h = bc^b^c^d.
// Stage 1 registers the 12 un-combined component bits per lane so no
// cross-component XOR happens before a register (non-completeness); the
// components are compressed into two output shares after that register.
// OUT_REG=1 adds a second register after compression.

// One lane: component register plus share compression.
module shared_sbox_lane (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [3:0] i_sh0,   // {d0,c0,b0,a0}
    input  logic [3:0] i_sh1,   // {d1,c1,b1,a1}
    input  logic       i_ra,
    input  logic       i_rb,
    output logic [3:0] o_sh0,   // {h,g,f,e} share 0
    output logic [3:0] o_sh1    // {h,g,f,e} share 1
);
    logic w_a0, w_b0, w_c0, w_d0;
    logic w_a1, w_b1, w_c1, w_d1;
    logic [3:0] r_e;
    logic [1:0] r_f;
    logic [1:0] r_g;
    logic [3:0] r_h;

    assign {w_d0, w_c0, w_b0, w_a0} = i_sh0;
    assign {w_d1, w_c1, w_b1, w_a1} = i_sh1;

    // Component register; each bit is a function of at most one share of
    // any variable pair, refreshed with ra (e terms) and rb (h terms).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e <= '0;
            r_f <= '0;
            r_g <= '0;
            r_h <= '0;
        end else if (i_en) begin
            r_e[0] <= (w_c0 & w_d0) ^ 1'b1 ^ i_ra;
            r_e[1] <= (w_c1 & w_d1) ^ w_a0 ^ i_ra;
            r_e[2] <= (w_c0 & w_d1) ^ i_ra;
            r_e[3] <= (w_c1 & w_d0) ^ w_a1 ^ i_ra;
            r_f    <= {w_b1, w_b0};
            r_g    <= {w_c0, w_c1};            // cross-share: g0 = c1, g1 = c0
            r_h[0] <= (w_b0 & w_c0) ^ i_rb;
            r_h[1] <= (w_b0 & w_c1) ^ w_b0 ^ w_d1 ^ i_rb;
            r_h[2] <= (w_b1 & w_c0) ^ w_c0 ^ w_d0 ^ i_rb;
            r_h[3] <= (w_b1 & w_c1) ^ w_b1 ^ w_c1 ^ i_rb;
        end
    end

    // Compression reads register outputs only.
    assign o_sh0 = {r_h[0] ^ r_h[1], r_g[0], r_f[0], r_e[0] ^ r_e[1]};
    assign o_sh1 = {r_h[2] ^ r_h[3], r_g[1], r_f[1], r_e[2] ^ r_e[3]};
endmodule

module shared_sbox_layer #(
    parameter int NLANE   = 16,
    parameter bit OUT_REG = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    shared_sbox_layer_if.slave bus
);
    logic                 r_v1;
    logic                 w_s1_adv;
    logic                 w_in_ready;
    logic                 w_accept;
    logic [4*NLANE-1:0]   w_c_sh0;
    logic [4*NLANE-1:0]   w_c_sh1;

    // Stage 1 can take a beat when empty or when its content leaves now.
    // Independent of in_valid/rnd_valid so upstream never sees a loop.
    assign w_in_ready    = !r_v1 | w_s1_adv;
    assign w_accept      = bus.in_valid & bus.rnd_valid & w_in_ready;
    assign bus.in_ready  = w_in_ready;
    // Guards are only taken together with a data beat.
    assign bus.rnd_ready = bus.in_valid & w_in_ready;

    // Stage-1 occupancy: reloaded whenever the stage is free to change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
        end else if (w_in_ready) begin
            r_v1 <= w_accept;
        end
    end

    for (genvar i = 0; i < NLANE; i++) begin : g_lane
        shared_sbox_lane u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .i_en  (w_accept),
            .i_sh0 (bus.in_sh0[4*i +: 4]),
            .i_sh1 (bus.in_sh1[4*i +: 4]),
            .i_ra  (bus.rnd[2*i]),
            .i_rb  (bus.rnd[2*i+1]),
            .o_sh0 (w_c_sh0[4*i +: 4]),
            .o_sh1 (w_c_sh1[4*i +: 4])
        );
    end

    if (OUT_REG) begin : g_oreg
        logic               r_v2;
        logic [4*NLANE-1:0] r_sh0;
        logic [4*NLANE-1:0] r_sh1;

        assign w_s1_adv = !r_v2 | bus.out_ready;

        // Output register: refills when empty or draining, holds on stall.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v2  <= 1'b0;
                r_sh0 <= '0;
                r_sh1 <= '0;
            end else if (w_s1_adv) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_sh0 <= w_c_sh0;
                    r_sh1 <= w_c_sh1;
                end
            end
        end

        assign bus.out_valid = r_v2;
        assign bus.out_sh0   = r_sh0;
        assign bus.out_sh1   = r_sh1;
    end else begin : g_ocomb
        assign w_s1_adv      = bus.out_ready;
        assign bus.out_valid = r_v1;
        assign bus.out_sh0   = w_c_sh0;
        assign bus.out_sh1   = w_c_sh1;
    end
endmodule

// File: tb/tb_shared_sbox_layer.sv
// Bench for shared_sbox_layer: three instances (4 lanes/latency 1,
// 4 lanes/latency 2, 32 lanes/latency 1) on common stimulus, with a
// nibble-level reference of the unmasked function and per-instance
// expected-output FIFOs.
module tb_shared_sbox_layer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid = 1'b0;
    logic         rnd_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] sh0 = '0;
    logic [127:0] sh1 = '0;
    logic [63:0]  rnd = '0;

    int n_tests = 0;
    int n_fail  = 0;

    shared_sbox_layer_if #(.NLANE(4))  b0 ();
    shared_sbox_layer_if #(.NLANE(4))  b1 ();
    shared_sbox_layer_if #(.NLANE(32)) b2 ();

    assign b0.in_valid = in_valid;  assign b1.in_valid = in_valid;  assign b2.in_valid = in_valid;
    assign b0.rnd_valid = rnd_valid; assign b1.rnd_valid = rnd_valid; assign b2.rnd_valid = rnd_valid;
    assign b0.out_ready = out_ready; assign b1.out_ready = out_ready; assign b2.out_ready = out_ready;
    assign b0.in_sh0 = sh0[15:0];   assign b1.in_sh0 = sh0[15:0];   assign b2.in_sh0 = sh0;
    assign b0.in_sh1 = sh1[15:0];   assign b1.in_sh1 = sh1[15:0];   assign b2.in_sh1 = sh1;
    assign b0.rnd = rnd[7:0];       assign b1.rnd = rnd[7:0];       assign b2.rnd = rnd;

    shared_sbox_layer #(.NLANE(4), .OUT_REG(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    shared_sbox_layer #(.NLANE(4), .OUT_REG(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    shared_sbox_layer #(.NLANE(32), .OUT_REG(1'b0)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    logic         o_valid [3];
    logic         i_rdy   [3];
    logic         r_rdy   [3];
    logic [127:0] o_sh0   [3];
    logic [127:0] o_sh1   [3];

    assign o_valid[0] = b0.out_valid; assign o_valid[1] = b1.out_valid; assign o_valid[2] = b2.out_valid;
    assign i_rdy[0] = b0.in_ready;    assign i_rdy[1] = b1.in_ready;    assign i_rdy[2] = b2.in_ready;
    assign r_rdy[0] = b0.rnd_ready;   assign r_rdy[1] = b1.rnd_ready;   assign r_rdy[2] = b2.rnd_ready;
    assign o_sh0[0] = {112'b0, b0.out_sh0}; assign o_sh1[0] = {112'b0, b0.out_sh1};
    assign o_sh0[1] = {112'b0, b1.out_sh0}; assign o_sh1[1] = {112'b0, b1.out_sh1};
    assign o_sh0[2] = b2.out_sh0;           assign o_sh1[2] = b2.out_sh1;

    // Expected unmasked outputs per instance, in acceptance order.
    logic [127:0] exp_mem [3][4096];
    logic [3:0]   in_lane0 [4096];
    int           wp [3] = '{0, 0, 0};
    int           rp [3] = '{0, 0, 0};
    // Output share-0 variation per unmasked input nibble (instance 0, lane 0).
    bit           have [16];
    bit           dif  [16];
    logic [3:0]   first [16];

    function automatic logic [3:0] f_nib(input logic [3:0] x);
        logic a, b, c, d;
        {d, c, b, a} = x;
        return {(b & c) ^ b ^ c ^ d, c, b, (c & d) ^ a ^ 1'b1};
    endfunction

    function automatic logic [127:0] f_vec(input logic [127:0] u);
        logic [127:0] r;
        r = '0;
        for (int l = 0; l < 32; l++) r[4*l +: 4] = f_nib(u[4*l +: 4]);
        return r;
    endfunction

    function automatic logic [127:0] msk(input int k);
        return (k < 2) ? 128'hFFFF : {128{1'b1}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [127:0] u);
        sh0 = {$urandom, $urandom, $urandom, $urandom};
        sh1 = sh0 ^ u;
        rnd = {$urandom, $urandom};
    endtask

    task automatic rand_beat();
        drive({$urandom, $urandom, $urandom, $urandom});
    endtask

    // Scoreboard, sampled mid-cycle: predicts the transfers of the next edge.
    initial begin
        logic [127:0] p0 [3];
        logic [127:0] p1 [3];
        bit           st [3];
        logic [127:0] u;
        logic [3:0]   x;
        for (int k = 0; k < 3; k++) st[k] = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!rst_n) begin
                    rp[k] = wp[k];
                    st[k] = 1'b0;
                end else begin
                    if (st[k]) begin
                        chk($sformatf("stall_valid[%0d]", k), 128'(o_valid[k]), 128'(1));
                        chk($sformatf("stall_sh0[%0d]", k), o_sh0[k], p0[k]);
                        chk($sformatf("stall_sh1[%0d]", k), o_sh1[k], p1[k]);
                    end
                    if (o_valid[k] && out_ready) begin
                        n_tests++;
                        assert (rp[k] != wp[k]) else begin
                            n_fail++;
                            $error("FAIL extra_beat[%0d]: got %0h want none", k, o_sh0[k] ^ o_sh1[k]);
                        end
                        if (rp[k] != wp[k]) begin
                            chk($sformatf("data[%0d]", k), o_sh0[k] ^ o_sh1[k], exp_mem[k][rp[k] & 4095]);
                            if (k == 0) begin
                                x = in_lane0[rp[k] & 4095];
                                if (!have[x]) begin
                                    have[x]  = 1'b1;
                                    first[x] = o_sh0[0][3:0];
                                end else if (first[x] != o_sh0[0][3:0]) begin
                                    dif[x] = 1'b1;
                                end
                            end
                            rp[k]++;
                        end
                    end
                    if (in_valid && rnd_valid && i_rdy[k]) begin
                        u = sh0 ^ sh1;
                        exp_mem[k][wp[k] & 4095] = f_vec(u) & msk(k);
                        if (k == 0) in_lane0[wp[k] & 4095] = u[3:0];
                        wp[k]++;
                    end
                    st[k] = o_valid[k] && !out_ready;
                    p0[k] = o_sh0[k];
                    p1[k] = o_sh1[k];
                end
            end
        end
    end

    initial begin
        int acc0, acc1;
        logic [3:0]   xv;
        logic [3:0]   pat;
        logic [127:0] u;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", 128'(o_valid[k]), 128'(0));
            chk("rst_sh0", o_sh0[k], '0);
            chk("rst_sh1", o_sh1[k], '0);
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk("rst_in_ready", 128'(i_rdy[k]), 128'(1));

        // Known nibbles 0,F,6,9 -> 1,7,F,8; latency 1 vs 2.
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; rnd_valid = 1'b1;
        drive(128'h96F0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("vec0_valid", 128'(o_valid[0]), 128'(1));
        chk("vec0_value", o_sh0[0] ^ o_sh1[0], 128'h8F71);
        chk("vec1_early", 128'(o_valid[1]), 128'(0));
        @(negedge clk);
        chk("vec1_valid", 128'(o_valid[1]), 128'(1));
        chk("vec1_value", o_sh0[1] ^ o_sh1[1], 128'h8F71);
        chk("vec0_gone", 128'(o_valid[0]), 128'(0));

        // All 16 nibbles x 64 random sharings/guards.
        @(posedge clk); #1;
        in_valid = 1'b1;
        for (int x = 0; x < 16; x++) begin
            for (int r = 0; r < 64; r++) begin
                xv = x[3:0];
                drive({32{xv}});
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("sweep_drain", 128'(wp[k] - rp[k]), 128'(0));
        for (int x = 0; x < 16; x++) chk($sformatf("share_varies[%0d]", x), 128'(dif[x]), 128'(1));

        // Backpressure from empty: count acceptances under out_ready=0.
        out_ready = 1'b0; in_valid = 1'b1;
        acc0 = 0; acc1 = 0;
        repeat (5) begin
            rand_beat();
            @(negedge clk);
            if (in_valid && rnd_valid && i_rdy[0]) acc0++;
            if (in_valid && rnd_valid && i_rdy[1]) acc1++;
            @(posedge clk); #1;
        end
        chk("bp_acc_lat2", 128'(acc1), 128'(2));
        chk("bp_acc_lat1", 128'(acc0), 128'(1));
        chk("bp_ready_low", 128'(i_rdy[1]), 128'(0));

        // out_ready toggling 1,0,0,1 with continuous input.
        pat = 4'b1001;
        for (int i = 0; i < 32; i++) begin
            out_ready = pat[i % 4];
            rand_beat();
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("bp_drain", 128'(wp[k] - rp[k]), 128'(0));

        // Guard starvation: beat waits, rnd_ready still reflects in_ready.
        in_valid = 1'b1; rnd_valid = 1'b0;
        rand_beat();
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk("starve_rnd_ready", 128'(r_rdy[k]), 128'(1));
                chk("starve_no_out", 128'(o_valid[k]), 128'(0));
            end
            @(posedge clk); #1;
        end
        rnd_valid = 1'b1;
        @(negedge clk);
        chk("starve_ready", 128'(i_rdy[0]), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("starve_out0", 128'(o_valid[0]), 128'(1));
        chk("starve_out2", 128'(o_valid[2]), 128'(1));
        repeat (3) @(posedge clk);
        #1;

        // Reset with two beats in flight in the latency-2 instance.
        out_ready = 1'b0; in_valid = 1'b1;
        rand_beat();
        @(posedge clk); #1;
        rand_beat();
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_full", 128'(i_rdy[1]), 128'(0));
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("mid_rst_valid", 128'(o_valid[k]), 128'(0));
            chk("mid_rst_sh0", o_sh0[k], '0);
            chk("mid_rst_sh1", o_sh1[k], '0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 128'(i_rdy[1]), 128'(1));
        out_ready = 1'b1; in_valid = 1'b1;
        u = {112'b0, 16'($urandom)};
        drive(u);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_lat1", 128'(o_valid[1]), 128'(0));
        @(negedge clk);
        chk("post_rst_lat2", 128'(o_valid[1]), 128'(1));
        chk("post_rst_value", o_sh0[1] ^ o_sh1[1], f_vec(u) & 128'hFFFF);
        repeat (2) @(posedge clk);
        #1;

        // 1000 back-to-back beats.
        in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            rand_beat();
            @(negedge clk);
            chk("stream_ready", 128'(i_rdy[2]), 128'(1));
            if (i > 0) chk("stream_valid", 128'(o_valid[2]), 128'(1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("stream_drain", 128'(wp[k] - rp[k]), 128'(0));
        chk("stream_count", 128'(wp[2] >= 1000), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
